// File: rtl/ps2_kbd_pkg.sv
// rtl/ps2_kbd_pkg.sv - shared constants and types for the PS/2 keyboard bus interface
// Purpose: register addresses, status bit positions and transmit FSM states.
// Ports: none (package).
package ps2_kbd_pkg;

  localparam logic REG_STATUS = 1'b0;
  localparam logic REG_DATA   = 1'b1;

  localparam int ST_RX_RDY = 0;
  localparam int ST_RX_IE  = 1;
  localparam int ST_TX_RDY = 2;
  localparam int ST_TX_IE  = 3;
  localparam int ST_OVR    = 4;
  localparam int ST_ERR    = 5;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_WAIT = 1'b1
  } tx_state_t;

endpackage

// File: rtl/ps2_kbd_if_fifo.sv
// rtl/ps2_kbd_if_fifo.sv - receive byte FIFO for the PS/2 keyboard interface
// Purpose: single-clock FIFO with push/pop, full/empty flags and occupancy count.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push, push_data   write request and byte
//   pop               read request (no-op when empty)
//   head              byte at the read pointer (undefined when empty)
//   empty, full       occupancy flags
//   count             number of stored bytes
module kbd_rx_fifo #(
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     empty,
  output logic                     full,
  output logic [FIFO_DEPTH_LOG2:0] count
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;

  logic [7:0]                 mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic                       do_push;
  logic                       do_pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign head  = mem[rd_ptr];

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is not reset; contents are meaningless once the pointers clear.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ps2_kbd_if.sv
// rtl/ps2_kbd_if.sv - CPU-bus register interface for a PS/2 keyboard host controller
// Purpose: buffers received scan codes, holds one transmit byte, raises a level irq.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   stb, we, addr, data_in            single-cycle bus access (addr 0 status, 1 data)
//   data_out, ack                     combinational read data, acknowledge (= stb)
//   irq                               registered level interrupt
//   rcv_data, rcv_error, rcv_strobe   received byte from the controller
//   xmt_ready, xmt_data, xmt_strobe   transmit handshake with the controller
module ps2_kbd_if
  import ps2_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb,
  input  logic        we,
  input  logic        addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  output logic        irq,
  input  logic [7:0]  rcv_data,
  input  logic        rcv_error,
  input  logic        rcv_strobe,
  input  logic        xmt_ready,
  output logic [7:0]  xmt_data,
  output logic        xmt_strobe
);

  localparam int CW = FIFO_DEPTH_LOG2 + 1;

  logic            rx_ie, tx_ie, ovr, err, tx_full;
  logic [7:0]      tx_hold;
  tx_state_t       state, state_nxt;

  logic [7:0]      fifo_head;
  logic            fifo_empty, fifo_full;
  logic [CW-1:0]   fifo_count;

  logic            wr_status, wr_data, rd_data;
  logic            rx_push, push_ok, pop_ok, ovr_set, err_set;
  logic            rx_ie_n, tx_ie_n, tx_full_n, rx_rdy_n;
  logic [31:0]     status_word;
  logic            unused_ok;

  assign unused_ok = &{1'b0, data_in[31:8]};

  assign wr_status = stb &  we & (addr == REG_STATUS);
  assign wr_data   = stb &  we & (addr == REG_DATA);
  assign rd_data   = stb & ~we & (addr == REG_DATA);

  assign rx_push = rcv_strobe & ~rcv_error;
  assign err_set = rcv_strobe &  rcv_error;
  assign pop_ok  = rd_data & ~fifo_empty;
  assign push_ok = rx_push & (~fifo_full | pop_ok);
  assign ovr_set = rx_push & fifo_full & ~rd_data;

  kbd_rx_fifo #(.FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (rcv_data),
    .pop       (rd_data),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  always_comb begin
    status_word            = '0;
    status_word[ST_RX_RDY] = ~fifo_empty;
    status_word[ST_RX_IE]  = rx_ie;
    status_word[ST_TX_RDY] = ~tx_full;
    status_word[ST_TX_IE]  = tx_ie;
    status_word[ST_OVR]    = ovr;
    status_word[ST_ERR]    = err;
  end

  assign data_out = (addr == REG_DATA) ? {24'h0, (fifo_empty ? 8'h00 : fifo_head)} : status_word;
  assign ack      = stb;
  assign xmt_data = tx_hold;

  always_comb begin
    state_nxt  = state;
    xmt_strobe = 1'b0;
    case (state)
      TX_IDLE: if (tx_full) state_nxt = TX_WAIT;
      TX_WAIT: if (xmt_ready) begin
        xmt_strobe = 1'b1;
        state_nxt  = TX_IDLE;
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

  // irq is registered from next-state values so it rises together with the
  // status bit that causes it rather than a cycle behind.
  assign rx_ie_n   = wr_status ? data_in[ST_RX_IE] : rx_ie;
  assign tx_ie_n   = wr_status ? data_in[ST_TX_IE] : tx_ie;
  assign tx_full_n = (wr_data & ~tx_full) | (tx_full & ~xmt_strobe);
  assign rx_rdy_n  = push_ok | (fifo_count > CW'(1)) | (~fifo_empty & ~pop_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= TX_IDLE;
      rx_ie   <= 1'b0;
      tx_ie   <= 1'b0;
      ovr     <= 1'b0;
      err     <= 1'b0;
      tx_full <= 1'b0;
      tx_hold <= 8'h00;
      irq     <= 1'b0;
    end else begin
      state   <= state_nxt;
      rx_ie   <= rx_ie_n;
      tx_ie   <= tx_ie_n;
      // Set wins over a write-1-to-clear in the same cycle.
      ovr     <= ovr_set | (ovr & ~(wr_status & data_in[ST_OVR]));
      err     <= err_set | (err & ~(wr_status & data_in[ST_ERR]));
      tx_full <= tx_full_n;
      if (wr_data && !tx_full) tx_hold <= data_in[7:0];
      irq     <= (rx_ie_n & rx_rdy_n) | (tx_ie_n & ~tx_full_n);
    end
  end

endmodule

// File: tb/tb_ps2_kbd_if.sv
// tb/tb_ps2_kbd_if.sv - self-checking bench for ps2_kbd_if against a queue-based model
module tb_ps2_kbd_if;

  logic        clk = 1'b0;
  logic        rst, stb, we, addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack, irq;
  logic [7:0]  rcv_data;
  logic        rcv_error, rcv_strobe, xmt_ready;
  logic [7:0]  xmt_data;
  logic        xmt_strobe;

  always #5 clk = ~clk;

  ps2_kbd_if #(.FIFO_DEPTH_LOG2(4)) dut (
    .clk(clk), .rst(rst), .stb(stb), .we(we), .addr(addr), .data_in(data_in),
    .data_out(data_out), .ack(ack), .irq(irq),
    .rcv_data(rcv_data), .rcv_error(rcv_error), .rcv_strobe(rcv_strobe),
    .xmt_ready(xmt_ready), .xmt_data(xmt_data), .xmt_strobe(xmt_strobe)
  );

  int checks = 0;
  int passed = 0;

  // Behavioural model: the FIFO is a plain queue; tx timing is "strobe on the
  // first cycle with xmt_ready once the held byte has been visible for a cycle".
  logic [7:0] q[$];
  bit         m_rx_ie, m_tx_ie, m_ovr, m_err, m_tx_full, m_irq;
  logic [7:0] m_hold;
  int         m_age;

  logic [31:0] s_dout;
  logic        s_irq, s_strobe;
  logic [7:0]  s_xdata;

  function automatic logic [31:0] m_status();
    return {26'h0, m_err, m_ovr, m_tx_ie, !m_tx_full, m_rx_ie, (q.size() != 0)};
  endfunction

  function automatic bit m_strobe();
    return m_tx_full && (m_age >= 1) && xmt_ready;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic model_update();
    bit strb, ovr_s, err_s;
    if (rst) begin
      q.delete();
      m_rx_ie = 0; m_tx_ie = 0; m_ovr = 0; m_err = 0; m_tx_full = 0;
      m_hold = 8'h00; m_age = 0; m_irq = 0;
      return;
    end
    strb  = m_strobe();
    ovr_s = 0;
    err_s = 0;
    if (stb && !we && addr && q.size() > 0) void'(q.pop_front());
    if (rcv_strobe) begin
      if (rcv_error) err_s = 1;
      else if (q.size() == 16) ovr_s = 1;
      else q.push_back(rcv_data);
    end
    if (stb && we && !addr) begin
      m_rx_ie = data_in[1];
      m_tx_ie = data_in[3];
      if (data_in[4]) m_ovr = 0;
      if (data_in[5]) m_err = 0;
    end
    if (ovr_s) m_ovr = 1;
    if (err_s) m_err = 1;
    if (stb && we && addr && !m_tx_full) begin
      m_hold = data_in[7:0];
      m_tx_full = 1;
      m_age = 0;
    end else if (strb) begin
      m_tx_full = 0;
    end else if (m_tx_full) begin
      m_age++;
    end
    m_irq = (m_rx_ie && q.size() > 0) || (m_tx_ie && !m_tx_full);
  endtask

  task automatic step();
    logic [7:0] head;
    @(negedge clk);
    head     = (q.size() != 0) ? q[0] : 8'h00;
    s_dout   = data_out;
    s_irq    = irq;
    s_strobe = xmt_strobe;
    s_xdata  = xmt_data;
    check("ack", ack, stb);
    check("irq", irq, m_irq);
    check("xmt_strobe", xmt_strobe, m_strobe());
    check("xmt_data", xmt_data, m_hold);
    check("data_out", data_out, addr ? {24'h0, head} : m_status());
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_idle();
    stb = 0; we = 0; addr = 0; data_in = '0;
    rcv_strobe = 0; rcv_error = 0; rcv_data = '0;
  endtask

  task automatic bus_rd(input logic a);
    stb = 1; we = 0; addr = a;
    step();
    set_idle();
  endtask

  task automatic bus_wr(input logic a, input logic [31:0] d);
    stb = 1; we = 1; addr = a; data_in = d;
    step();
    set_idle();
  endtask

  task automatic rcv(input logic [7:0] d, input logic e);
    rcv_strobe = 1; rcv_error = e; rcv_data = d;
    step();
    set_idle();
  endtask

  int n_strobe;
  logic [7:0] strobe_byte;

  initial begin
    set_idle();
    xmt_ready = 0;
    rst = 1;
    step();
    step();
    rst = 0;

    // Reset state
    bus_rd(0);
    check("lit_reset_status", s_dout, 32'h4);
    check("lit_reset_irq", s_irq, 1'b0);
    check("lit_reset_xdata", s_xdata, 8'h00);

    // Three scan codes in, three out, then empty read
    rcv(8'h1C, 0); rcv(8'hF0, 0); rcv(8'h1C, 0);
    bus_rd(0); check("lit_rx_rdy_set", s_dout, 32'h5);
    bus_rd(1); check("lit_rd0", s_dout, 32'h1C);
    bus_rd(1); check("lit_rd1", s_dout, 32'hF0);
    bus_rd(1); check("lit_rd2", s_dout, 32'h1C);
    bus_rd(1); check("lit_rd_empty", s_dout, 32'h0);
    bus_rd(0); check("lit_rx_rdy_clr", s_dout, 32'h4);

    // Overrun on the 17th byte, then write-1-to-clear
    for (int i = 0; i < 17; i++) rcv(8'(i), 0);
    bus_rd(0); check("lit_ovr_set", s_dout, 32'h15);
    bus_wr(0, 32'h10);
    bus_rd(0); check("lit_ovr_clr", s_dout, 32'h5);

    // Full FIFO: pop and push in the same cycle
    stb = 1; we = 0; addr = 1; rcv_strobe = 1; rcv_data = 8'h2A;
    step();
    set_idle();
    check("lit_pop_push_head", s_dout, 32'h0);
    bus_rd(0); check("lit_no_ovr", s_dout, 32'h5);
    for (int i = 0; i < 16; i++) bus_rd(1);
    check("lit_last_2a", s_dout, 32'h2A);
    bus_rd(0); check("lit_drained", s_dout, 32'h4);

    // Receive error with rx_ie set
    bus_wr(0, 32'h2);
    rcv(8'h55, 1);
    bus_rd(0); check("lit_err_status", s_dout, 32'h26);
    step(); check("lit_err_irq", s_irq, 1'b0);
    bus_wr(0, 32'h22);

    // irq follows rx_rdy
    rcv(8'h1C, 0);
    step(); check("lit_irq_push", s_irq, 1'b1);
    bus_rd(1); check("lit_irq_pop_data", s_dout, 32'h1C);
    step(); check("lit_irq_pop", s_irq, 1'b0);
    bus_wr(0, 32'h0);

    // Transmit held off by xmt_ready, second write ignored
    xmt_ready = 0;
    bus_wr(1, 32'hED);
    for (int i = 0; i < 50; i++) begin
      if (i == 10) bus_wr(1, 32'h11);
      else step();
    end
    xmt_ready = 1;
    n_strobe = 0;
    strobe_byte = 8'h00;
    for (int i = 0; i < 15; i++) begin
      step();
      if (s_strobe) begin
        n_strobe++;
        strobe_byte = s_xdata;
      end
    end
    check("lit_tx_once", n_strobe, 1);
    check("lit_tx_byte", strobe_byte, 8'hED);
    bus_rd(0); check("lit_tx_rdy", s_dout[2], 1'b1);

    // Reset with tx pending and data buffered
    xmt_ready = 0;
    rcv(8'h33, 0);
    bus_wr(1, 32'h77);
    step();
    rst = 1;
    rcv_strobe = 1; rcv_data = 8'h44;
    step();
    set_idle();
    rst = 0;
    xmt_ready = 1;
    n_strobe = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (s_strobe) n_strobe++;
    end
    check("lit_rst_no_tx", n_strobe, 0);
    bus_rd(0); check("lit_rst_status", s_dout, 32'h4);

    // Randomised traffic against the model
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst        = ($urandom_range(0, 299) == 0);
      if ((cyc / 500) % 2 == 1) stb = ($urandom_range(0, 3) != 0);
      else                      stb = ($urandom_range(0, 2) == 0);
      we         = $urandom_range(0, 1);
      addr       = $urandom_range(0, 1);
      data_in    = $urandom;
      rcv_strobe = $urandom_range(0, 1);
      rcv_error  = ($urandom_range(0, 9) == 0);
      rcv_data   = 8'($urandom);
      xmt_ready  = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 0;
    set_idle();
    step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_if.md
Name: ps2_kbd_if

Overview:
Bus-side keyboard interface that sits directly downstream of the PS/2 host controller. It consumes received scan-code bytes (rcv_data/rcv_error/rcv_strobe) into a receive FIFO, and exposes status, control and data registers to the CPU bus. It also holds one command byte for transmission and hands it to the controller via the xmt_ready/xmt_strobe handshake. It raises a level interrupt on receive-data-available or transmit-ready.

Parameters:
FIFO_DEPTH_LOG2, 4, log2 of receive FIFO depth (default 16 entries)

Ports:
clk  in  1  system clock
rst  in  1  reset
stb  in  1  bus strobe, single-cycle access
we  in  1  bus write enable
addr  in  1  register select: 0 = status/control, 1 = data
data_in  in  32  bus write data
data_out  out  32  bus read data, combinational from addr and registers
ack  out  1  bus acknowledge, equals stb (zero wait states)
irq  out  1  level interrupt request
rcv_data  in  8  byte from controller
rcv_error  in  1  framing/parity error for the current byte
rcv_strobe  in  1  one-cycle pulse, byte valid
xmt_ready  out→in  1  input: controller idle and line quiet
xmt_data  out  8  byte to transmit
xmt_strobe  out  1  one-cycle transmit request

Behaviour:
- Reset (rst, synchronous, active-high; clock clk):
  - FIFO empty; rx_ie=0, tx_ie=0, ovr=0, err=0, tx_full=0.
  - xmt_strobe=0, xmt_data=0, irq=0.
- Status register (addr 0), read value:
  - bit0 rx_rdy = FIFO not empty
  - bit1 rx_ie
  - bit2 tx_rdy = ~tx_full
  - bit3 tx_ie
  - bit4 ovr (sticky)
  - bit5 err (sticky)
  - bits 31:6 = 0
- Status register (addr 0), write:
  - data_in[1] loads rx_ie; data_in[3] loads tx_ie.
  - data_in[4]=1 clears ovr; data_in[5]=1 clears err (write-1-to-clear).
  - Other bits are ignored.
- Data register (addr 1), read:
  - Returns {24'h0, FIFO head}. If the FIFO is empty it returns 0.
  - A read with stb & ~we pops the head at the clock edge. A pop on an empty FIFO is a no-op.
- Data register (addr 1), write:
  - If tx_full=0: load tx_hold=data_in[7:0] and set tx_full=1.
  - If tx_full=1: the write is dropped, with no side effects.
- Receive path, on rcv_strobe:
  - rcv_error=1: discard the byte, set err.
  - FIFO full and no simultaneous pop: discard the byte, set ovr.
  - Otherwise push rcv_data. The byte is visible on the bus (rx_rdy=1) in the cycle after the strobe.
- Simultaneous push and pop:
  - Both take effect and the count is unchanged.
  - When full, a simultaneous pop frees a slot, so the push is accepted and ovr is not set.
  - When empty, a simultaneous pop is a no-op and the push is accepted.
- Sticky set vs clear: if a set condition and a write-1-clear occur in the same cycle, set wins.
- Pointers: FIFO_DEPTH_LOG2-bit read/write pointers that wrap modulo depth. Count is FIFO_DEPTH_LOG2+1 bits; full when count==depth.
- Transmit FSM, two states:
  - TX_IDLE: go to TX_WAIT when tx_full=1.
  - TX_WAIT: when xmt_ready=1, assert xmt_strobe for exactly one cycle, clear tx_full, return to TX_IDLE.
  - xmt_data = tx_hold, stable while tx_full=1.
- Transmit latency: at least 2 cycles from the bus write to xmt_strobe.
- Interrupt: irq registered = (rx_ie & rx_rdy) | (tx_ie & tx_rdy). It updates one cycle after the causing event.
- Reset mid-operation: a pending tx byte is discarded and FIFO contents are lost. A rcv_strobe coincident with rst is ignored.

Decomposition:
- Shared package ps2_kbd_pkg holds:
  - register addresses REG_STATUS=0, REG_DATA=1
  - status bit indices ST_RX_RDY..ST_ERR
  - TX FSM state encodings
- Sub-module kbd_rx_fifo:
  - synchronous single-clock FIFO with push/pop, full/empty and count
  - parameterised by FIFO_DEPTH_LOG2
- The top level holds the registers, TX FSM, irq and bus decode.

Test Plan:
- Three strobes 0x1C, 0xF0, 0x1C, then three data reads → reads return 0x1C, 0xF0, 0x1C; status bit0 goes 1 then 0; a fourth read returns 0.
- 17 strobes with depth 16, no reads → 16 bytes stored, 17th dropped, ovr=1; write status 0x10 → ovr=0.
- rcv_strobe with rcv_error=1, data 0x55 → FIFO stays empty, err=1, irq stays 0 with rx_ie=1.
- Write data 0xED with xmt_ready=0 for 50 cycles, then 1 → xmt_strobe pulses once with xmt_data=0xED; tx_rdy=1 afterwards; a second write while pending is ignored.
- FIFO full, then data-read and rcv_strobe 0x2A in the same cycle → no overrun, count stays 16, 0x2A is the last byte read out.
- rx_ie=1, push 0x1C → irq=1 next cycle; pop → irq=0 next cycle. rst asserted with tx pending → xmt_strobe never fires, all status bits 0 except tx_rdy.
